// File: rtl/decoder2to4_selftest.sv
// ----------------------------------------------------------------------------
// decoder2to4_selftest
//
// Sequential stimulus generator and response checker for three 2-to-4
// decoder implementations (behavioural, structural, dataflow) that share one
// registered select pair. A run walks sel = {Sel1,Sel0} through 0..3. Each
// select value is held for PRESCALE settle cycles plus one CHECK cycle. In
// CHECK all twelve decoder outputs are compared against the one-hot code for
// sel.
//
// Handshake: start is a plain request level with no ready/ack. It is sampled
// only in IDLE, and one sampled high starts a run. A start seen while busy or
// in DONE is dropped, not queued. Completion is reported by a single-cycle
// done pulse. pass/err_cnt/first_* are valid from done until the next
// accepted start.
//
// Parameters
//   PRESCALE  settle cycles per select value (1..255)
//   ERR_W     width of err_cnt; the counter saturates at 2^ERR_W-1
//
// Ports
//   clk, rst_n       clock (rising edge), async active-low reset
//   start            run request, sampled only in IDLE
//   Sel0, Sel1       registered select to the decoders
//   bh_Y0..3         behavioural decoder outputs
//   st_Y0..3         structural decoder outputs
//   df_Y0..3         dataflow decoder outputs
//   busy             high from the cycle after start is accepted until done
//   done             one-cycle pulse at the end of a run
//   pass             err_cnt==0, valid from done until next start
//   err_cnt          number of failing (implementation, vector) pairs
//   first_sel        select value of the first failing vector
//   first_mask       implementations failing on that vector, [2]=bh [1]=st [0]=df
//   dbg_state_o      current FSM state (IDLE=0 SETTLE=1 CHECK=2 DONE=3)
// ----------------------------------------------------------------------------
module decoder2to4_selftest #(
  parameter int PRESCALE = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             Sel0,
  output logic             Sel1,
  input  logic             bh_Y0,
  input  logic             bh_Y1,
  input  logic             bh_Y2,
  input  logic             bh_Y3,
  input  logic             st_Y0,
  input  logic             st_Y1,
  input  logic             st_Y2,
  input  logic             st_Y3,
  input  logic             df_Y0,
  input  logic             df_Y1,
  input  logic             df_Y2,
  input  logic             df_Y3,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       first_sel,
  output logic [2:0]       first_mask,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Sum width leaves headroom for adding up to three errors before clamping.
  localparam int             SUM_W    = ERR_W + 2;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [7:0]     CNT_LAST = 8'(PRESCALE - 1);

  state_e             state_q;
  logic [1:0]         sel_q;
  logic [7:0]         cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic [ERR_W-1:0]   err_q;
  logic [1:0]         fsel_q;
  logic [2:0]         fmask_q;

  // Response evaluation, only consumed while in CHECK.
  logic [3:0]         exp_y;
  logic [3:0]         bh_y;
  logic [3:0]         st_y;
  logic [3:0]         df_y;
  logic [2:0]         mask_d;
  logic [SUM_W-1:0]   err_sum;
  logic [ERR_W-1:0]   err_d;

  always_comb begin
    exp_y   = 4'b0001 << sel_q;
    bh_y    = {bh_Y3, bh_Y2, bh_Y1, bh_Y0};
    st_y    = {st_Y3, st_Y2, st_Y1, st_Y0};
    df_y    = {df_Y3, df_Y2, df_Y1, df_Y0};
    mask_d  = {(bh_y != exp_y), (st_y != exp_y), (df_y != exp_y)};
    err_sum = SUM_W'(err_q) + SUM_W'(mask_d[2]) + SUM_W'(mask_d[1])
            + SUM_W'(mask_d[0]);
    // Clamp instead of wrapping so a badly broken DUT never reads as clean.
    if (err_sum > SUM_W'(ERR_MAX)) begin
      err_d = ERR_MAX;
    end else begin
      err_d = err_sum[ERR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= 2'd0;
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fsel_q  <= 2'd0;
      fmask_q <= 3'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          sel_q <= 2'd0;
          if (start) begin
            state_q <= ST_SETTLE;
            busy_q  <= 1'b1;
            cnt_q   <= 8'd0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            fsel_q  <= 2'd0;
            fmask_q <= 3'd0;
          end
        end

        ST_SETTLE: begin
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          err_q <= err_d;
          // Only the first failing vector is recorded; later ones just count.
          if ((mask_d != 3'd0) && (fmask_q == 3'd0)) begin
            fsel_q  <= sel_q;
            fmask_q <= mask_d;
          end
          if (sel_q == 2'd3) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            pass_q  <= (err_d == '0);
          end else begin
            sel_q   <= sel_q + 2'd1;
            cnt_q   <= 8'd0;
            state_q <= ST_SETTLE;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          sel_q   <= 2'd0;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign Sel0        = sel_q[0];
  assign Sel1        = sel_q[1];
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_cnt     = err_q;
  assign first_sel   = fsel_q;
  assign first_mask  = fmask_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_decoder2to4_selftest.sv
module tb_decoder2to4_selftest;

  localparam int P = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (ERR_W=8) ----------------
  logic       sel0, sel1, busy, done, pass;
  logic [7:0] err_cnt;
  logic [1:0] first_sel, dbg_state;
  logic [2:0] first_mask;
  logic [3:0] ref_y, bh, st, df;
  int         dec_mode = 0;

  decoder2to4_selftest #(.PRESCALE(P), .ERR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .Sel0(sel0), .Sel1(sel1),
    .bh_Y0(bh[0]), .bh_Y1(bh[1]), .bh_Y2(bh[2]), .bh_Y3(bh[3]),
    .st_Y0(st[0]), .st_Y1(st[1]), .st_Y2(st[2]), .st_Y3(st[3]),
    .df_Y0(df[0]), .df_Y1(df[1]), .df_Y2(df[2]), .df_Y3(df[3]),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_sel(first_sel), .first_mask(first_mask), .dbg_state_o(dbg_state)
  );

  // Decoder models with selectable faults.
  always_comb begin
    ref_y = 4'b0001 << {sel1, sel0};
    bh = ref_y;
    st = ref_y;
    df = ref_y;
    case (dec_mode)
      1: bh[2] = 1'b0;
      2: begin bh = 4'd0; st = 4'd0; df = 4'd0; end
      3: st = {ref_y[3:2], ref_y[0], ref_y[1]};
      4: df[3] = 1'b1;
      5: begin bh = ~ref_y; df = ~ref_y; end
      default: ;
    endcase
  end

  // ---------------- saturation DUT (ERR_W=2, all Y tied 0) ----------------
  logic       s_sel0, s_sel1, s_busy, s_done, s_pass;
  logic [1:0] s_err, s_first_sel, s_dbg;
  logic [2:0] s_first_mask;

  decoder2to4_selftest #(.PRESCALE(P), .ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start),
    .Sel0(s_sel0), .Sel1(s_sel1),
    .bh_Y0(1'b0), .bh_Y1(1'b0), .bh_Y2(1'b0), .bh_Y3(1'b0),
    .st_Y0(1'b0), .st_Y1(1'b0), .st_Y2(1'b0), .st_Y3(1'b0),
    .df_Y0(1'b0), .df_Y1(1'b0), .df_Y2(1'b0), .df_Y3(1'b0),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_cnt(s_err),
    .first_sel(s_first_sel), .first_mask(s_first_mask), .dbg_state_o(s_dbg)
  );

  // ---------------- counters / check ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         mode;
    logic       pass;
    logic [7:0] err;
    logic [1:0] fsel;
    logic [2:0] fmask;
  } vec_t;
  vec_t vecs[6];

  // ---------------- scoreboard ----------------
  // main: {pass, err[7:0], fsel[1:0], fmask[2:0]}; sat: {pass, err[1:0], fsel, fmask}
  logic [13:0] exp_q[$];
  logic [7:0]  sat_q[$];
  localparam logic [7:0] SAT_EXP = {1'b0, 2'd3, 2'd0, 3'b111};
  logic [13:0] e_main;
  logic [7:0]  e_sat;

  always begin
    @(posedge clk);
    #1;
    if (done) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: done with empty expected queue at %0t", $time);
      end else begin
        e_main = exp_q.pop_front();
        check("res_pass", pass, e_main[13]);
        check("res_err_cnt", err_cnt, e_main[12:5]);
        check("res_first_sel", first_sel, e_main[4:3]);
        check("res_first_mask", first_mask, e_main[2:0]);
      end
    end
    if (s_done) begin
      n_tests++;
      if (sat_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_sat_done: done with empty expected queue at %0t", $time);
      end else begin
        e_sat = sat_q.pop_front();
        check("sat_pass", s_pass, e_sat[7]);
        check("sat_err_cnt", s_err, e_sat[6:5]);
        check("sat_first_sel", s_first_sel, e_sat[4:3]);
        check("sat_first_mask", s_first_mask, e_sat[2:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int n_done;
    int done_k;
    dec_mode = vecs[i].mode;
    exp_q.push_back({vecs[i].pass, vecs[i].err, vecs[i].fsel, vecs[i].fmask});
    sat_q.push_back(SAT_EXP);
    pulse_start();
    check("busy_after_accept", busy, 1'b1);
    check("err_cleared_on_accept", err_cnt, 8'd0);
    n_done = 0;
    done_k = -1;
    for (int k = 1; k <= 26; k++) begin
      @(posedge clk);
      #1;
      if (k == 2 || k == 7 || k == 12 || k == 17)
        check("sel_walk", {sel1, sel0}, (k - 2) / 5);
      if (k == 19) check("busy_mid_run", busy, 1'b1);
      if (k == 21) check("busy_after_done", busy, 1'b0);
      if (done) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (k == 26) begin
        check("hold_err_cnt", err_cnt, vecs[i].err);
        check("hold_pass", pass, vecs[i].pass);
      end
    end
    check("done_count", n_done, 1);
    check("done_latency", done_k, 4 * (P + 1));
  endtask

  // Start re-pulsed during the run and during DONE; the held start then
  // launches a second run on the first IDLE cycle.
  task automatic restart_seq();
    int n_done;
    int dk1;
    int dk2;
    dec_mode = vecs[1].mode;
    exp_q.push_back({vecs[1].pass, vecs[1].err, vecs[1].fsel, vecs[1].fmask});
    sat_q.push_back(SAT_EXP);
    pulse_start();
    n_done = 0;
    dk1 = -1;
    dk2 = -1;
    for (int k = 1; k <= 46; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) start = 1'b1;
      if (k == 5) start = 1'b0;
      if (k == 7) check("no_restart_sel", {sel1, sel0}, 2'd1);
      if (k == 20) begin
        start = 1'b1;
        exp_q.push_back({vecs[1].pass, vecs[1].err, vecs[1].fsel, vecs[1].fmask});
        sat_q.push_back(SAT_EXP);
      end
      if (k == 22) begin
        start = 1'b0;
        check("rerun_busy", busy, 1'b1);
        check("rerun_err_cleared", err_cnt, 8'd0);
        check("rerun_state", dbg_state, 2'd1);
      end
      if (done) begin
        n_done++;
        if (dk1 < 0) dk1 = k;
        else if (dk2 < 0) dk2 = k;
      end
    end
    check("restart_done_count", n_done, 2);
    check("restart_done1", dk1, 20);
    check("restart_done2", dk2, 42);
  endtask

  task automatic reset_seq();
    int n_done;
    int busy_seen;
    dec_mode = 2;
    pulse_start();
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
    end
    check("pre_reset_err_nonzero", (err_cnt != 8'd0), 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {sel1, sel0, busy, done, pass, err_cnt, first_sel, first_mask}, 18'd0);
    check("async_reset_state", dbg_state, 2'd0);
    check("async_reset_sat_err", s_err, 2'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    busy_seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done || s_done) n_done++;
      if (busy) busy_seen++;
    end
    check("no_done_after_reset", n_done, 0);
    check("idle_after_reset", busy_seen, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 1'b1, 8'd0,  2'd0, 3'b000};  // correct decoders
    vecs[1] = '{1, 1'b0, 8'd1,  2'd2, 3'b100};  // bh_Y2 stuck 0
    vecs[2] = '{2, 1'b0, 8'd12, 2'd0, 3'b111};  // all Y tied 0
    vecs[3] = '{3, 1'b0, 8'd2,  2'd0, 3'b010};  // st_Y0/st_Y1 swapped
    vecs[4] = '{4, 1'b0, 8'd3,  2'd0, 3'b001};  // df_Y3 stuck 1
    vecs[5] = '{5, 1'b0, 8'd8,  2'd0, 3'b101};  // bh and df inverted

    #12;
    check("reset_outputs",
          {sel0, sel1, busy, done, pass, err_cnt, first_sel, first_mask}, 18'd0);
    check("reset_state", dbg_state, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_no_start", busy, 1'b0);

    for (int i = 0; i < 6; i++) run_vec(i);
    restart_seq();
    reset_seq();
    run_vec(0);

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    check("sat_scoreboard_drained", sat_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
